// File: rtl/hl2_proto_pkg.sv
// Shared constants and parser state encoding for the HL2 receive-frame protocol.
package hl2_proto_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'h7F;
  localparam int unsigned CC_BYTES    = 5;
  localparam int unsigned SLOT_BYTES  = 8;
  localparam int unsigned FRAME_BYTES = 512;

  typedef enum logic [2:0] {
    StHunt0,
    StHunt1,
    StHunt2,
    StCc,
    StSlots
  } parser_state_e;

endpackage

// File: rtl/rx_frame_parser.sv
// Byte-serial parser for 512-byte frames: three sync bytes, five C&C bytes, then
// fixed 8-byte slots carrying an audio word (bytes 0..3) and a TX IQ word (bytes 4..7).
module rx_frame_parser
  import hl2_proto_pkg::*;
#(
  parameter int unsigned SLOTS_PER_FRAME = 63
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        run,
  input  logic        rx_enable,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [6:0]  cmd_addr,
  output logic        cmd_mox,
  output logic [31:0] cmd_data,
  output logic        iq_valid,
  output logic [31:0] iq_data,
  output logic        audio_valid,
  output logic [31:0] audio_data,
  output logic        in_sync,
  output logic [7:0]  sync_err_count
);

  localparam logic [2:0] CcLast    = 3'(CC_BYTES - 1);
  localparam logic [2:0] SlotLast  = 3'(SLOT_BYTES - 1);
  localparam logic [2:0] AudioLast = 3'(SLOT_BYTES / 2 - 1);
  localparam logic [5:0] LastSlot  = 6'(SLOTS_PER_FRAME - 1);

  parser_state_e state_q;
  logic [2:0]    idx_q;
  logic [5:0]    slot_q;
  logic [31:0]   sr_q;
  logic          in_sync_q;
  logic [7:0]    err_q;

  logic          cmd_valid_q, iq_valid_q, audio_valid_q;
  logic [6:0]    cmd_addr_q;
  logic          cmd_mox_q;
  logic [31:0]   cmd_data_q, iq_data_q, audio_data_q;

  logic          adv;
  logic          cmd_evt, audio_evt, iq_evt;
  logic [31:0]   word;
  logic [7:0]    err_inc;
  logic          is_sync;

  // Decode byte-consuming cycles and the word completed by the current byte.
  always_comb begin
    adv       = run & rx_enable;
    is_sync   = (rx_data == SYNC_BYTE);
    // Shift register holds the three previous bytes, so any word ends with rx_data.
    word      = {sr_q[23:0], rx_data};
    cmd_evt   = adv && (state_q == StCc) && (idx_q == CcLast);
    audio_evt = adv && (state_q == StSlots) && (idx_q == AudioLast);
    iq_evt    = adv && (state_q == StSlots) && (idx_q == SlotLast);
    err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  // Frame FSM: sync hunt, C&C capture and slot walking; run low aborts to hunting.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= StHunt0;
      idx_q     <= '0;
      slot_q    <= '0;
      sr_q      <= '0;
      in_sync_q <= 1'b0;
      err_q     <= '0;
    end else if (!run) begin
      state_q   <= StHunt0;
      idx_q     <= '0;
      slot_q    <= '0;
      in_sync_q <= 1'b0;
    end else if (rx_enable) begin
      unique case (state_q)
        StHunt0: begin
          // Idle hunting: non-sync bytes are expected here and not counted.
          if (is_sync) state_q <= StHunt1;
        end
        StHunt1: begin
          if (is_sync) begin
            state_q <= StHunt2;
          end else begin
            state_q <= StHunt0;
            err_q   <= err_inc;
          end
        end
        StHunt2: begin
          if (is_sync) begin
            state_q   <= StCc;
            idx_q     <= '0;
            in_sync_q <= 1'b1;
          end else begin
            state_q <= StHunt0;
            err_q   <= err_inc;
          end
        end
        StCc: begin
          sr_q <= word;
          if (idx_q == CcLast) begin
            state_q <= StSlots;
            idx_q   <= '0;
            slot_q  <= '0;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StSlots: begin
          sr_q <= word;
          if (idx_q == SlotLast) begin
            idx_q <= '0;
            if (slot_q == LastSlot) begin
              state_q   <= StHunt0;
              slot_q    <= '0;
              in_sync_q <= 1'b0;
            end else begin
              slot_q <= slot_q + 6'd1;
            end
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        default: state_q <= StHunt0;
      endcase
    end
  end

  // Output registers: one-cycle valid pulses, data words held until the next update.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cmd_valid_q   <= 1'b0;
      iq_valid_q    <= 1'b0;
      audio_valid_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_mox_q     <= 1'b0;
      cmd_data_q    <= '0;
      iq_data_q     <= '0;
      audio_data_q  <= '0;
    end else begin
      cmd_valid_q   <= cmd_evt;
      iq_valid_q    <= iq_evt;
      audio_valid_q <= audio_evt;
      if (cmd_evt) begin
        cmd_addr_q <= sr_q[31:25];
        cmd_mox_q  <= sr_q[24];
        cmd_data_q <= word;
      end
      if (audio_evt) audio_data_q <= word;
      if (iq_evt)    iq_data_q    <= word;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_addr       = cmd_addr_q;
  assign cmd_mox        = cmd_mox_q;
  assign cmd_data       = cmd_data_q;
  assign iq_valid       = iq_valid_q;
  assign iq_data        = iq_data_q;
  assign audio_valid    = audio_valid_q;
  assign audio_data     = audio_data_q;
  assign in_sync        = in_sync_q;
  assign sync_err_count = err_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Randomized bench for rx_frame_parser: frames are built from protocol rules and the
// expected command/audio/IQ words queued as each frame is generated.
module tb_rx_frame_parser;
  import hl2_proto_pkg::*;

  localparam int Slots = 63;

  logic        clock = 1'b0;
  logic        rst, run, rx_enable;
  logic [7:0]  rx_data;
  logic        cmd_valid, iq_valid, audio_valid, in_sync, cmd_mox;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_data, iq_data, audio_data;
  logic [7:0]  sync_err_count;

  int n_cmp = 0, n_fail = 0;
  int n_cmd = 0, n_iq = 0, n_aud = 0;
  // Expected events: {kind, C0 (cmd only), word}; kind 1=cmd, 2=audio, 3=iq.
  logic [41:0] exp_q[$];

  rx_frame_parser #(.SLOTS_PER_FRAME(Slots)) dut (
    .clock         (clock),
    .rst           (rst),
    .run           (run),
    .rx_enable     (rx_enable),
    .rx_data       (rx_data),
    .cmd_valid     (cmd_valid),
    .cmd_addr      (cmd_addr),
    .cmd_mox       (cmd_mox),
    .cmd_data      (cmd_data),
    .iq_valid      (iq_valid),
    .iq_data       (iq_data),
    .audio_valid   (audio_valid),
    .audio_data    (audio_data),
    .in_sync       (in_sync),
    .sync_err_count(sync_err_count)
  );

  always #5 clock = ~clock;

  // Scoreboard: every observed pulse must match the next expected event in order.
  always @(negedge clock) begin
    logic [41:0] obs, want;
    int nv;
    nv = int'(cmd_valid) + int'(iq_valid) + int'(audio_valid);
    if (nv != 0) begin
      if (cmd_valid) begin
        n_cmd++;
        obs = {2'd1, cmd_addr, cmd_mox, cmd_data};
      end else if (audio_valid) begin
        n_aud++;
        obs = {2'd2, 8'h00, audio_data};
      end else begin
        n_iq++;
        obs = {2'd3, 8'h00, iq_data};
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_order got=%h required=no event", obs);
      end else begin
        want = exp_q.pop_front();
        if (nv != 1 || obs !== want) begin
          n_fail++;
          $display("FAIL event_order got=%h (%0d pulses) required=%h", obs, nv, want);
        end
      end
    end
  end

  function automatic logic [7:0] rand_not_sync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC_BYTE) b = 8'h00;
    return b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_enable = 1'b0;
      rx_data   = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    idle(g);
    @(negedge clock);
    run       = 1'b1;
    rx_enable = 1'b1;
    rx_data   = b;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1; run = 1'b0; rx_enable = 1'b0;
    exp_q.delete();
    @(negedge clock);
    rst = 1'b0; run = 1'b1;
  endtask

  // One frame; chk_timing (gap 0 only) checks pulse latency on slot 0,
  // abort_slot >= 0 drops run for one cycle inside that slot.
  task automatic send_frame(input logic [7:0] c0, input logic [31:0] cdata, input int max_gap,
                            input logic [63:0] slot0, input bit chk_timing, input int abort_slot);
    logic [63:0] cur;
    logic [31:0] last_aud;
    last_aud = audio_data;
    repeat (3) send_byte(SYNC_BYTE, max_gap);
    send_byte(c0, max_gap);
    if (chk_timing) begin
      n_cmp++;
      if (in_sync !== 1'b1) begin
        n_fail++; $display("FAIL in_sync_after_sync got=%b required=1", in_sync);
      end
    end
    exp_q.push_back({2'd1, c0, cdata});
    for (int i = 0; i < 4; i++) send_byte(cdata[31-8*i -: 8], max_gap);
    for (int s = 0; s < Slots; s++) begin
      cur = (chk_timing && s == 0) ? slot0 : {$urandom, $urandom};
      if (s == abort_slot) begin
        send_byte(cur[63:56], max_gap);
        send_byte(cur[55:48], max_gap);
        @(negedge clock);
        run = 1'b0; rx_enable = 1'b1; rx_data = SYNC_BYTE;
        @(negedge clock);
        run = 1'b1; rx_enable = 1'b0;
        n_cmp++;
        if (in_sync !== 1'b0) begin
          n_fail++; $display("FAIL in_sync_after_abort got=%b required=0", in_sync);
        end
        n_cmp++;
        if (audio_data !== last_aud) begin
          n_fail++; $display("FAIL audio_hold_after_abort got=%h required=%h", audio_data, last_aud);
        end
        for (int k = 0; k < 8 * (Slots - s) - 2; k++) send_byte(rand_not_sync(), max_gap);
        return;
      end
      exp_q.push_back({2'd2, 8'h00, cur[63:32]});
      exp_q.push_back({2'd3, 8'h00, cur[31:0]});
      last_aud = cur[63:32];
      for (int k = 0; k < 8; k++) begin
        send_byte(cur[63-8*k -: 8], max_gap);
        if (chk_timing && s == 0 && k == 3) begin
          n_cmp++;
          if (audio_valid !== 1'b0) begin
            n_fail++; $display("FAIL audio_early got=%b required=0", audio_valid);
          end
        end
        if (chk_timing && s == 0 && k == 4) begin
          n_cmp++;
          if (audio_valid !== 1'b1 || audio_data !== slot0[63:32]) begin
            n_fail++;
            $display("FAIL audio_latency got=%b/%h required=1/%h", audio_valid, audio_data,
                     slot0[63:32]);
          end
        end
        if (chk_timing && s == 1 && k == 0) begin
          n_cmp++;
          if (iq_valid !== 1'b1 || iq_data !== slot0[31:0]) begin
            n_fail++;
            $display("FAIL iq_latency got=%b/%h required=1/%h", iq_valid, iq_data, slot0[31:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; rx_enable = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({cmd_valid, iq_valid, audio_valid, in_sync, cmd_addr, cmd_mox, cmd_data, iq_data,
         audio_data, sync_err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b%b%b%b %h %b %h %h %h %h required=all zero", cmd_valid,
               iq_valid, audio_valid, in_sync, cmd_addr, cmd_mox, cmd_data, iq_data, audio_data,
               sync_err_count);
    end
    @(negedge clock);
    rst = 1'b0; run = 1'b1;
  endtask

  task automatic test_basic_frame();
    int c0, a0, i0;
    do_reset();
    c0 = n_cmd; a0 = n_aud; i0 = n_iq;
    send_frame(8'h13, 32'hDEADBEEF, 0, 64'h0001_0002_1234_ABCD, 1'b1, -1);
    idle(3);
    n_cmp++;
    if (n_cmd - c0 != 1 || n_aud - a0 != 63 || n_iq - i0 != 63) begin
      n_fail++;
      $display("FAIL basic_pulse_counts got=%0d/%0d/%0d required=1/63/63", n_cmd - c0,
               n_aud - a0, n_iq - i0);
    end
    n_cmp++;
    if (cmd_addr !== 7'h09 || cmd_mox !== 1'b1 || cmd_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_cmd_fields got=%h/%b/%h required=09/1/deadbeef", cmd_addr, cmd_mox,
               cmd_data);
    end
    n_cmp++;
    if (in_sync !== 1'b0 || sync_err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_end_state got=%b/%0d required=0/0", in_sync, sync_err_count);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_missing_events got=%0d left required=0", exp_q.size());
    end
  endtask

  task automatic test_sync_errors();
    int i0;
    do_reset();
    send_byte(SYNC_BYTE, 0);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h55, 0);
    idle(1);
    n_cmp++;
    if (sync_err_count !== 8'd1) begin
      n_fail++; $display("FAIL sync_err_single got=%0d required=1", sync_err_count);
    end
    i0 = n_iq;
    send_frame(8'($urandom), $urandom, 1, 64'h0, 1'b0, -1);
    idle(3);
    n_cmp++;
    if (n_iq - i0 != 63 || exp_q.size() != 0 || sync_err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL sync_err_then_frame got=%0d iq/%0d left/%0d err required=63/0/1",
               n_iq - i0, exp_q.size(), sync_err_count);
    end
    for (int p = 0; p < 300; p++) begin
      send_byte(SYNC_BYTE, 1);
      send_byte(rand_not_sync(), 1);
      if (p == 99) begin
        idle(1);
        n_cmp++;
        if (sync_err_count !== 8'd101) begin
          n_fail++; $display("FAIL sync_err_count_101 got=%0d required=101", sync_err_count);
        end
      end
    end
    idle(2);
    n_cmp++;
    if (sync_err_count !== 8'd255) begin
      n_fail++; $display("FAIL sync_err_saturate got=%0d required=255", sync_err_count);
    end
  endtask

  task automatic test_run_drop();
    int c0, a0, i0;
    do_reset();
    c0 = n_cmd; a0 = n_aud; i0 = n_iq;
    send_frame(8'($urandom), $urandom, 0, 64'h0, 1'b0, 20);
    idle(3);
    n_cmp++;
    if (n_iq - i0 != 20 || n_aud - a0 != 20 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_drop_counts got=%0d iq/%0d aud/%0d left required=20/20/0", n_iq - i0,
               n_aud - a0, exp_q.size());
    end
    send_frame(8'($urandom), $urandom, 2, 64'h0, 1'b0, -1);
    idle(3);
    n_cmp++;
    if (n_cmd - c0 != 2 || n_iq - i0 != 83 || exp_q.size() != 0 || sync_err_count !== 8'd0)
    begin
      n_fail++;
      $display("FAIL run_drop_recover got=%0d cmd/%0d iq/%0d left/%0d err required=2/83/0/0",
               n_cmd - c0, n_iq - i0, exp_q.size(), sync_err_count);
    end
  endtask

  task automatic test_back_to_back();
    int c0, a0, i0;
    do_reset();
    c0 = n_cmd; a0 = n_aud; i0 = n_iq;
    send_frame(8'($urandom), $urandom, 3, 64'h0, 1'b0, -1);
    send_frame(8'($urandom), $urandom, 3, 64'h0, 1'b0, -1);
    idle(3);
    n_cmp++;
    if (n_cmd - c0 != 2 || n_iq - i0 != 126 || n_aud - a0 != 126) begin
      n_fail++;
      $display("FAIL b2b_counts got=%0d/%0d/%0d required=2/126/126", n_cmd - c0, n_iq - i0,
               n_aud - a0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || sync_err_count !== 8'd0 || in_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_state got=%0d left/%0d err/%b sync required=0/0/0", exp_q.size(),
               sync_err_count, in_sync);
    end
  endtask

  task automatic test_reset_mid_cc();
    int c0;
    c0 = n_cmd;
    repeat (3) send_byte(SYNC_BYTE, 0);
    send_byte(8'h13, 0);
    send_byte(8'hDE, 0);
    @(negedge clock);
    rst = 1'b1; rx_enable = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({cmd_valid, iq_valid, audio_valid, in_sync, cmd_addr, cmd_mox, cmd_data, iq_data,
         audio_data, sync_err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_cc_outputs got=%b%b%b%b %h %b %h %h %h %h required=all zero",
               cmd_valid, iq_valid, audio_valid, in_sync, cmd_addr, cmd_mox, cmd_data, iq_data,
               audio_data, sync_err_count);
    end
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 40; k++) send_byte(rand_not_sync(), 0);
    idle(3);
    n_cmp++;
    if (n_cmd != c0 || in_sync !== 1'b0 || cmd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_cc_no_cmd got=%0d cmd/%b sync/%h data required=0/0/0",
               n_cmd - c0, in_sync, cmd_data);
    end
    send_frame(8'($urandom), $urandom, 1, 64'h0, 1'b0, -1);
    idle(3);
    n_cmp++;
    if (n_cmd - c0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_cc_recover got=%0d cmd/%0d left required=1/0", n_cmd - c0,
               exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_sync_errors();
    test_run_drop();
    test_back_to_back();
    test_reset_mid_cc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
